aer_readout_scheduler: RTL

AER_READOUT_SCHEDULER -- requirements
Module: aer_readout_scheduler

---
 rtl/aer_readout_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/aer_readout_scheduler.sv
// Round-robin AER readout: grants one requesting tile at a time over a four-phase
// req/ack handshake and queues {tile_id, event_word} into a show-ahead FIFO.
//   state | meaning
//   IDLE  | pick next requesting tile at/after rr_ptr when FIFO has room
//   ACK   | single cycle: ack winner, push its event, advance rr_ptr
//   WAIT  | hold ack until winner drops req, or flag timeout
module aer_readout_scheduler #(
  parameter int N_TILES = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255,
  localparam int TID_W  = $clog2(N_TILES),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [N_TILES-1:0]         tile_req_i,
  input  logic [N_TILES*WIDTH-1:0]   tile_data_i,
  output logic [N_TILES-1:0]         tile_ack_o,
  output logic [TID_W+WIDTH-1:0]     evt_data_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  input  logic                       flush_i,
  output logic [LVL_W-1:0]           fifo_level_o,
  output logic                       timeout_err_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int EW    = TID_W + WIDTH;

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t             state_q, state_d;
  logic [TID_W-1:0]   rr_q, rr_d, win_q, win_d, pick;
  logic               pick_vld;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               armed_q;
  logic [N_TILES-1:0] ack_q, ack_d;

  logic [TID_W-1:0]   cand [N_TILES];
  logic [WIDTH-1:0]   tile_word [N_TILES];

  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               full, empty, push, pop;
  logic [EW-1:0]      push_word;

  always_comb begin
    for (int i = 0; i < N_TILES; i++) begin
      cand[i]      = TID_W'((int'(rr_q) + i) % N_TILES);
      tile_word[i] = tile_data_i[i*WIDTH +: WIDTH];
    end
  end

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick     = rr_q;
    pick_vld = 1'b0;
    for (int i = N_TILES - 1; i >= 0; i--) begin
      if (tile_req_i[cand[i]]) begin
        pick     = cand[i];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (armed_q && pick_vld && !full) begin
          win_d   = pick;
          state_d = ACK;
        end
      end
      ACK: begin
        rr_d    = (win_q == TID_W'(N_TILES - 1)) ? '0 : win_q + 1'b1;
        cnt_d   = CNT_W'(TIMEOUT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (!tile_req_i[win_q]) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != IDLE) ack_d[win_d] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      armed_q <= 1'b1;
    end
  end

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign push      = (state_q == ACK) && !flush_i;
  assign pop       = !empty && evt_ready_i && !flush_i;
  assign push_word = {win_q, tile_word[win_q]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Gate the head so stale storage never shows while empty or in reset.
  assign evt_data_o    = empty ? '0 : mem[rd_ptr];
  assign evt_valid_o   = !empty;
  assign fifo_level_o  = level;
  assign tile_ack_o    = ack_q;
  assign timeout_err_o = err_q;

endmodule
